// File: rtl/core_pkg.sv
// Shared core definitions: widths, NOP encoding, reset PC and opcodes.
// Also carries the fetch queue entry layout used by fetch and decode.
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fq_entry_t;

    function automatic logic [XLEN-1:0] pc_plus4(
        input logic [XLEN-1:0] pc
    );
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory request/response channel between fetch and imem.
// master = fetch stage, slave = memory.
interface fetch_stage_if;
    import core_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous DEPTH-entry FIFO with push/pop/clear and occupancy count.
// Used for the returned-instruction queue and for the PC-tag queue.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_clear,
    input  logic                   i_push,
    input  logic [W-1:0]           i_data,
    input  logic                   i_pop,
    output logic [W-1:0]           o_data,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [AW:0]   r_count;

    logic w_push;
    logic w_pop;

    assign w_push = i_push && (r_count != FULL);
    assign w_pop  = i_pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            r_count <= r_count + (AW+1)'(w_push)
                               - (AW+1)'(w_pop);
        end
    end

    assign o_data  = r_mem[r_rd];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem requests, fetch queue, decode register.
// Optional FETCH_PERF_EN adds fetched/dropped/bubble counters.
module fetch_stage
    import core_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    fetch_stage_if.master     imem,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    input  logic              StallD,
    input  logic              FlushD,
    output logic              ValidD,
    output logic [XLEN-1:0]   InstrD,
    output logic [XLEN-1:0]   PCD,
    output logic [XLEN-1:0]   PCPlus4D
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_dropped,
    output logic [31:0]       perf_bubbles
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    // Stale responses can pile up across back-to-back redirects.
    localparam int DW = CW + 3;
    localparam logic [CW:0] LIM = (CW+1)'(DEPTH);

    logic [XLEN-1:0] r_pc;
    logic [DW-1:0]   r_discard;
    logic            r_valid_d;
    logic [XLEN-1:0] r_instr_d;
    logic [XLEN-1:0] r_pc_d;
    logic [XLEN-1:0] r_pc4_d;

    logic [CW-1:0]   w_out_cnt;
    logic [CW-1:0]   w_q_cnt;
    logic [XLEN-1:0] w_tag;
    fq_entry_t       w_head;
    fq_entry_t       w_push_e;
    logic            w_req_valid;
    logic            w_fire;
    logic            w_rsp;
    logic            w_drop;
    logic            w_accept;
    logic            w_q_empty;
    logic            w_pop;
    logic            w_bubble;

    assign w_rsp       = imem.imem_rsp_valid;
    assign w_q_empty   = (w_q_cnt == '0);
    assign w_req_valid = !reset && !redirect_valid
                      && (({1'b0, w_out_cnt} + {1'b0, w_q_cnt}) < LIM);
    assign w_fire      = w_req_valid && imem.imem_req_ready;
    assign w_drop      = w_rsp && (redirect_valid || (r_discard != '0));
    assign w_accept    = w_rsp && !w_drop;
    assign w_pop       = !redirect_valid && !StallD && !FlushD && !w_q_empty;
    assign w_bubble    = !redirect_valid && !StallD && !FlushD && w_q_empty;

    assign imem.imem_req_valid = w_req_valid;
    assign imem.imem_req_addr  = r_pc;

    assign w_push_e.instr = imem.imem_rsp_data;
    assign w_push_e.pc    = w_tag;

    // PC of each live in-flight request, in issue order.
    fetch_queue #(.DEPTH(DEPTH), .W(XLEN)) u_tag_q (
        .clk     (clk),
        .reset   (reset),
        .i_clear (redirect_valid),
        .i_push  (w_fire),
        .i_data  (r_pc),
        .i_pop   (w_accept),
        .o_data  (w_tag),
        .o_count (w_out_cnt)
    );

    fetch_queue #(.DEPTH(DEPTH), .W($bits(fq_entry_t))) u_fetch_q (
        .clk     (clk),
        .reset   (reset),
        .i_clear (redirect_valid),
        .i_push  (w_accept),
        .i_data  (w_push_e),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_q_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        end else if (w_fire) begin
            r_pc <= pc_plus4(r_pc);
        end
    end

    // Every request still in flight at a redirect becomes stale.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_discard <= '0;
        end else if (redirect_valid) begin
            r_discard <= r_discard + DW'(w_out_cnt) - DW'(w_rsp);
        end else if (w_drop) begin
            r_discard <= r_discard - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid_d <= 1'b0;
            r_instr_d <= NOP_INSTR;
            r_pc_d    <= '0;
            r_pc4_d   <= '0;
        end else if (redirect_valid || (!StallD && (FlushD || w_q_empty))) begin
            r_valid_d <= 1'b0;
            r_instr_d <= NOP_INSTR;
        end else if (!StallD) begin
            r_valid_d <= 1'b1;
            r_instr_d <= w_head.instr;
            r_pc_d    <= w_head.pc;
            r_pc4_d   <= pc_plus4(w_head.pc);
        end
    end

    assign ValidD   = r_valid_d;
    assign InstrD   = r_instr_d;
    assign PCD      = r_pc_d;
    assign PCPlus4D = r_pc4_d;

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_dropped;
    logic [31:0] r_perf_bubbles;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetched <= '0;
            r_perf_dropped <= '0;
            r_perf_bubbles <= '0;
        end else begin
            r_perf_fetched <= r_perf_fetched + 32'(w_accept);
            r_perf_dropped <= r_perf_dropped + 32'(w_drop);
            r_perf_bubbles <= r_perf_bubbles + 32'(w_bubble);
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_dropped = r_perf_dropped;
    assign perf_bubbles = r_perf_bubbles;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: in-order latency memory, queue-based reference
// model checked every cycle, plus directed literal expectations.
module tb_fetch_stage;
    import core_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        redir;
    logic [31:0] redir_pc;
    logic        stall;
    logic        flush;
    logic        ready;
    logic        ValidD;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
`ifdef FETCH_PERF_EN
    logic [31:0] pf;
    logic [31:0] pd;
    logic [31:0] pb;
`endif

    fetch_stage_if imem ();

    fetch_stage #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .reset          (rst),
        .imem           (imem),
        .redirect_valid (redir),
        .redirect_pc    (redir_pc),
        .StallD         (stall),
        .FlushD         (flush),
        .ValidD         (ValidD),
        .InstrD         (InstrD),
        .PCD            (PCD),
        .PCPlus4D       (PCPlus4D)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (pf),
        .perf_dropped   (pd),
        .perf_bubbles   (pb)
`endif
    );

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; bit stale; } infl_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;

    mreq_t mq[$];
    infl_t m_infl[$];
    ent_t  m_buf[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int lat = 1;

    logic [31:0] m_pc;
    logic        mV;
    logic [31:0] mI;
    logic [31:0] mP;
    logic [31:0] mP4;
    logic [31:0] m_fetched;
    logic [31:0] m_dropped;
    logic [31:0] m_bubbles;
    logic        obs_rv;
    logic [31:0] obs_addr;
    logic [2:0]  first_v;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic int live();
        int n = m_buf.size();
        foreach (m_infl[i]) if (!m_infl[i].stale) n++;
        return n;
    endfunction

    task automatic model_step(input logic rv, input logic mfire);
        infl_t h;
        ent_t  e;
        if (rst) begin
            m_pc = 32'h0;
            m_infl.delete();
            m_buf.delete();
            mV = 1'b0; mI = NOP_INSTR; mP = 32'h0; mP4 = 32'h0;
            m_fetched = 0; m_dropped = 0; m_bubbles = 0;
        end else begin
            if (redir) begin
                mV = 1'b0; mI = NOP_INSTR;
            end else if (!stall) begin
                if (!flush && m_buf.size() > 0) begin
                    e = m_buf.pop_front();
                    mV = 1'b1; mI = e.instr; mP = e.pc; mP4 = e.pc + 32'd4;
                end else begin
                    mV = 1'b0; mI = NOP_INSTR;
                    if (!flush) m_bubbles++;
                end
            end
            if (rv && m_infl.size() > 0) begin
                h = m_infl.pop_front();
                if (redir || h.stale) m_dropped++;
                else begin
                    m_buf.push_back('{memword(h.pc), h.pc});
                    m_fetched++;
                end
            end
            if (redir) begin
                foreach (m_infl[i]) m_infl[i].stale = 1'b1;
                m_buf.delete();
                m_pc = {redir_pc[31:2], 2'b00};
            end else if (mfire) begin
                m_infl.push_back('{m_pc, 1'b0});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic cycle();
        logic mfire;
        logic dfire;
        logic rv;
        logic [31:0] daddr;
        @(negedge clk);
        if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
            imem.imem_rsp_valid = 1'b1;
            imem.imem_rsp_data  = memword(mq[0].addr);
        end else begin
            imem.imem_rsp_valid = 1'b0;
            imem.imem_rsp_data  = 32'h0;
        end
        imem.imem_req_ready = ready;
        #1;
        mfire    = !rst && !redir && (live() < 4);
        obs_rv   = imem.imem_req_valid;
        obs_addr = imem.imem_req_addr;
        chk("req_valid", 32'(obs_rv), 32'(mfire));
        if (mfire) chk("req_addr", obs_addr, m_pc);
        mfire = mfire && ready;
        dfire = obs_rv && ready;
        daddr = obs_addr;
        rv    = imem.imem_rsp_valid;
        @(posedge clk);
        cyc++;
        if (rst) mq.delete();
        else begin
            if (rv) mq.delete(0);
            if (dfire) mq.push_back('{daddr, cyc + lat - 1});
        end
        model_step(rv, mfire);
        #1;
        chk("ValidD", 32'(ValidD), 32'(mV));
        chk("InstrD", InstrD, mI);
        chk("PCD", PCD, mP);
        chk("PCPlus4D", PCPlus4D, mP4);
`ifdef FETCH_PERF_EN
        chk("perf_fetched", pf, m_fetched);
        chk("perf_dropped", pd, m_dropped);
        chk("perf_bubbles", pb, m_bubbles);
`endif
    endtask

    task automatic wait_valid(input string name);
        int i = 0;
        while (ValidD !== 1'b1 && i < 20) begin
            cycle();
            i++;
        end
        chk(name, 32'(ValidD), 32'd1);
    endtask

    initial begin
        rst = 1'b1; redir = 1'b0; redir_pc = 32'h0;
        stall = 1'b0; flush = 1'b0; ready = 1'b0;
        imem.imem_req_ready = 1'b0;
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data  = 32'h0;
        m_pc = 0; mV = 0; mI = NOP_INSTR; mP = 0; mP4 = 0;
        m_fetched = 0; m_dropped = 0; m_bubbles = 0;

        cycle();
        cycle();
        chk("rst_instr", InstrD, 32'h0000_0013);
        chk("rst_pcd", PCD, 32'h0);

        // Streaming start, then memory backpressure.
        rst = 1'b0; ready = 1'b1; lat = 1;
        cycle(); first_v[2] = ValidD;
        cycle(); first_v[1] = ValidD;
        ready = 1'b0;
        cycle(); first_v[0] = ValidD;
        chk("first_valid", 32'(first_v), 32'b001);
        chk("first_instr", InstrD, 32'hC0DE_0000);
        chk("first_pcd", PCD, 32'h0);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) cycle();
            chk("hold_valid", 32'(obs_rv), 32'd1);
            chk("hold_addr", obs_addr, 32'h8);
        end
        chk("drained", 32'(ValidD), 32'd0);

        ready = 1'b1;
        repeat (3) cycle();
        stall = 1'b1;
        repeat (6) cycle();
        chk("cap_stop", 32'(obs_rv), 32'd0);
        stall = 1'b0;
        repeat (8) cycle();

        // Redirect with two requests outstanding at latency 3.
        ready = 1'b0;
        repeat (6) cycle();
        lat = 3; ready = 1'b1;
        repeat (2) cycle();
        redir = 1'b1; redir_pc = 32'h0000_0103;
        cycle();
        chk("redir_noreq", 32'(obs_rv), 32'd0);
        redir = 1'b0;
        wait_valid("redir_wait");
        chk("redir_pcd", PCD, 32'h100);
        chk("redir_instr", InstrD, 32'hC0DE_0100);
`ifdef FETCH_PERF_EN
        chk("redir_dropped", pd, 32'd2);
`endif

        // Redirect coinciding with FlushD, StallD and a response.
        lat = 1;
        repeat (5) cycle();
        redir = 1'b1; redir_pc = 32'h200; stall = 1'b1; flush = 1'b1;
        cycle();
        chk("combo_valid", 32'(ValidD), 32'd0);
        chk("combo_instr", InstrD, 32'h0000_0013);
        redir = 1'b0; stall = 1'b0; flush = 1'b0;
        cycle();
        chk("combo_rv", 32'(obs_rv), 32'd1);
        chk("combo_addr", obs_addr, 32'h200);

        // PC wrap at the top of the address space.
        repeat (3) cycle();
        redir = 1'b1; redir_pc = 32'hFFFF_FFFC;
        cycle();
        redir = 1'b0;
        cycle();
        chk("wrap_addr0", obs_addr, 32'hFFFF_FFFC);
        cycle();
        chk("wrap_addr1", obs_addr, 32'h0);
        wait_valid("wrap_wait");
        chk("wrap_pcd", PCD, 32'hFFFF_FFFC);
        chk("wrap_pc4", PCPlus4D, 32'h0);

        // Back-to-back redirects at long latency: the last one wins.
        lat = 4;
        repeat (3) cycle();
        redir = 1'b1; redir_pc = 32'h300;
        cycle();
        redir_pc = 32'h400;
        cycle();
        redir = 1'b0;
        wait_valid("b2b_wait");
        chk("b2b_pcd", PCD, 32'h400);

        // Reset in the middle of outstanding traffic.
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        wait_valid("mrst_wait");
        chk("mrst_pcd", PCD, 32'h0);
        repeat (4) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
